store_issue_stage: RTL and testbench

Single-entry store issue stage between the LSU issue port and the store buffer. It accepts one store request and checks its alignment. It requests a virtual-to-physical translation from the MMU, aligns the data and byte enables to the 64-bit dcache word, pushes the store into the speculative store buffer, and returns a completion or exception to the scoreboard.

---
 rtl/store_issue_stage.sv | 212 +++++++++++++++++++++
 tb/tb_store_issue_stage.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/store_issue_stage.sv
`default_nettype none
// ============================================================================
// Module   : store_issue_stage
// Purpose  : Single-entry store issue stage. Accepts one store from the LSU,
//            checks its alignment, requests address translation from the MMU,
//            aligns data/byte-enables to the 64-bit dcache word, pushes the
//            store into the speculative store buffer and returns a completion
//            (or exception) to the scoreboard.
// Ports    : clk_i/rst_ni          clock, async active-low reset
//            flush_i               kill any in-flight store
//            lsu_*                 request handshake, vaddr/data/size/id
//            translation_req_o,
//            vaddr_o, dtlb_*,
//            paddr_i, xcpt_*       MMU translation interface
//            sb_*                  store buffer push interface
//            result_*              completion / exception to scoreboard
// Revision : 1.0 - initial release
// ============================================================================
module store_issue_stage #(
  parameter int TRANS_ID_BITS = 3,
  parameter int VLEN          = 39,
  parameter int PLEN          = 56,
  parameter int XLEN          = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     lsu_valid_i,
  output logic                     lsu_ready_o,
  input  logic [VLEN-1:0]          vaddr_i,
  input  logic [XLEN-1:0]          data_i,
  input  logic [1:0]               size_i,
  input  logic [TRANS_ID_BITS-1:0] trans_id_i,
  output logic                     translation_req_o,
  output logic [VLEN-1:0]          vaddr_o,
  input  logic                     dtlb_hit_i,
  input  logic [PLEN-1:0]          paddr_i,
  input  logic                     xcpt_valid_i,
  input  logic [XLEN-1:0]          xcpt_cause_i,
  output logic                     sb_valid_o,
  output logic                     sb_valid_without_flush_o,
  input  logic                     sb_ready_i,
  output logic [PLEN-1:0]          sb_paddr_o,
  output logic [XLEN-1:0]          sb_data_o,
  output logic [7:0]               sb_be_o,
  output logic [1:0]               sb_data_size_o,
  output logic                     result_valid_o,
  output logic [TRANS_ID_BITS-1:0] result_trans_id_o,
  output logic                     result_xcpt_valid_o,
  output logic [XLEN-1:0]          result_xcpt_cause_o,
  output logic [XLEN-1:0]          result_xcpt_tval_o
);

  localparam int             OFF_W             = $clog2(XLEN / 8);
  localparam logic [XLEN-1:0] C_CAUSE_ST_MISAL = XLEN'(6);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_TRANSLATE = 2'd1,
    S_WAIT_SB   = 2'd2
  } state_e;

  state_e                   r_state, w_next;
  logic [VLEN-1:0]          r_vaddr;
  logic [XLEN-1:0]          r_data;
  logic [1:0]               r_size;
  logic [TRANS_ID_BITS-1:0] r_trans_id;
  logic                     r_misaligned;
  logic [PLEN-1:0]          r_paddr;

  logic                     w_ready, w_treq, w_push, w_res, w_xv;
  logic                     w_load_req, w_load_paddr, w_be_en;
  logic [XLEN-1:0]          w_cause, w_tval;
  logic [PLEN-1:0]          w_sb_paddr;
  logic                     w_misaligned_in;
  logic [7:0]               w_be_base;
  logic [OFF_W+2:0]         w_shamt;

  always_comb begin
    w_misaligned_in = 1'b0;
    case (size_i)
      2'd1:    w_misaligned_in = vaddr_i[0];
      2'd2:    w_misaligned_in = |vaddr_i[1:0];
      2'd3:    w_misaligned_in = |vaddr_i[2:0];
      default: w_misaligned_in = 1'b0;
    endcase
  end

  always_comb begin
    w_next       = r_state;
    w_ready      = 1'b0;
    w_treq       = 1'b0;
    w_push       = 1'b0;
    w_res        = 1'b0;
    w_xv         = 1'b0;
    w_cause      = '0;
    w_tval       = '0;
    w_load_req   = 1'b0;
    w_load_paddr = 1'b0;
    w_be_en      = 1'b0;
    w_sb_paddr   = '0;
    case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        if (lsu_valid_i && !flush_i) begin
          w_load_req = 1'b1;
          w_next     = S_TRANSLATE;
        end
      end
      S_TRANSLATE: begin
        w_be_en    = 1'b1;
        w_sb_paddr = paddr_i;
        if (r_misaligned) begin
          // Misaligned stores never reach the MMU.
          w_res   = 1'b1;
          w_xv    = 1'b1;
          w_cause = C_CAUSE_ST_MISAL;
          w_tval  = XLEN'(r_vaddr);
          w_next  = S_IDLE;
        end else begin
          w_treq = 1'b1;
          if (dtlb_hit_i) begin
            if (xcpt_valid_i) begin
              w_res   = 1'b1;
              w_xv    = 1'b1;
              w_cause = xcpt_cause_i;
              w_tval  = XLEN'(r_vaddr);
              w_next  = S_IDLE;
            end else if (sb_ready_i) begin
              w_push = 1'b1;
              w_res  = 1'b1;
              w_next = S_IDLE;
            end else begin
              w_load_paddr = 1'b1;
              w_next       = S_WAIT_SB;
            end
          end
        end
      end
      S_WAIT_SB: begin
        w_be_en    = 1'b1;
        w_sb_paddr = r_paddr;
        if (sb_ready_i) begin
          w_push = 1'b1;
          w_res  = 1'b1;
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
    if (flush_i) begin
      w_next       = S_IDLE;
      w_load_paddr = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= S_IDLE;
      r_vaddr      <= '0;
      r_data       <= '0;
      r_size       <= '0;
      r_trans_id   <= '0;
      r_misaligned <= 1'b0;
      r_paddr      <= '0;
    end else begin
      r_state <= w_next;
      if (w_load_req) begin
        r_vaddr      <= vaddr_i;
        r_data       <= data_i;
        r_size       <= size_i;
        r_trans_id   <= trans_id_i;
        r_misaligned <= w_misaligned_in;
      end
      if (w_load_paddr) begin
        r_paddr <= paddr_i;
      end
    end
  end

  // Byte-enable pattern before shifting into the addressed lane.
  always_comb begin
    w_be_base = 8'h01;
    case (r_size)
      2'd0:    w_be_base = 8'h01;
      2'd1:    w_be_base = 8'h03;
      2'd2:    w_be_base = 8'h0F;
      default: w_be_base = 8'hFF;
    endcase
  end

  assign w_shamt = {r_vaddr[OFF_W-1:0], 3'b000};

  assign lsu_ready_o              = w_ready;
  assign translation_req_o        = w_treq;
  assign vaddr_o                  = r_vaddr;
  assign sb_valid_without_flush_o = w_push;
  assign sb_valid_o               = w_push & ~flush_i;
  assign sb_paddr_o               = w_sb_paddr;
  assign sb_data_o                = r_data << w_shamt;
  // Gated in IDLE so the reset/idle value of the byte enables is zero.
  assign sb_be_o                  = w_be_en ? (w_be_base << r_vaddr[2:0]) : 8'h00;
  assign sb_data_size_o           = r_size;

  assign result_valid_o      = w_res & ~flush_i;
  assign result_trans_id_o   = (w_res & ~flush_i) ? r_trans_id : '0;
  assign result_xcpt_valid_o = w_xv & ~flush_i;
  assign result_xcpt_cause_o = flush_i ? '0 : w_cause;
  assign result_xcpt_tval_o  = flush_i ? '0 : w_tval;

endmodule
`default_nettype wire

// File: tb/tb_store_issue_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_store_issue_stage
// Purpose  : Directed, self-checking bench for store_issue_stage. Expected
//            pushes and completions are queued when the stimulus is driven
//            and compared when the DUT produces them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_store_issue_stage;

  logic        clk_i, rst_ni, flush_i, lsu_valid_i, lsu_ready_o;
  logic [38:0] vaddr_i, vaddr_o;
  logic [63:0] data_i, xcpt_cause_i, sb_data_o;
  logic [1:0]  size_i, sb_data_size_o;
  logic [2:0]  trans_id_i, result_trans_id_o;
  logic        translation_req_o, dtlb_hit_i, xcpt_valid_i;
  logic [55:0] paddr_i, sb_paddr_o;
  logic        sb_valid_o, sb_valid_without_flush_o, sb_ready_i;
  logic [7:0]  sb_be_o;
  logic        result_valid_o, result_xcpt_valid_o;
  logic [63:0] result_xcpt_cause_o, result_xcpt_tval_o;

  store_issue_stage #(.TRANS_ID_BITS(3), .VLEN(39), .PLEN(56), .XLEN(64)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o),
    .vaddr_i(vaddr_i), .data_i(data_i), .size_i(size_i), .trans_id_i(trans_id_i),
    .translation_req_o(translation_req_o), .vaddr_o(vaddr_o),
    .dtlb_hit_i(dtlb_hit_i), .paddr_i(paddr_i),
    .xcpt_valid_i(xcpt_valid_i), .xcpt_cause_i(xcpt_cause_i),
    .sb_valid_o(sb_valid_o), .sb_valid_without_flush_o(sb_valid_without_flush_o),
    .sb_ready_i(sb_ready_i), .sb_paddr_o(sb_paddr_o), .sb_data_o(sb_data_o),
    .sb_be_o(sb_be_o), .sb_data_size_o(sb_data_size_o),
    .result_valid_o(result_valid_o), .result_trans_id_o(result_trans_id_o),
    .result_xcpt_valid_o(result_xcpt_valid_o),
    .result_xcpt_cause_o(result_xcpt_cause_o),
    .result_xcpt_tval_o(result_xcpt_tval_o)
  );

  typedef struct packed {
    logic [2:0]  id;
    logic        xv;
    logic [63:0] cause;
    logic [63:0] tval;
  } res_t;

  typedef struct packed {
    logic [55:0] paddr;
    logic [63:0] data;
    logic [7:0]  be;
    logic [1:0]  size;
  } push_t;

  res_t  res_q[$];
  push_t push_q[$];
  res_t  r_exp;
  push_t p_exp;
  int    vecs = 0;
  int    errs = 0;

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every push/result seen must match the head of its queue.
  always @(negedge clk_i) begin
    if (rst_ni === 1'b1) begin
      if (result_valid_o === 1'b1) begin
        if (res_q.size() == 0) chk("unexpected_result", 1, 0);
        else begin
          r_exp = res_q.pop_front();
          chk("res_id",    64'(result_trans_id_o), 64'(r_exp.id));
          chk("res_xv",    64'(result_xcpt_valid_o), 64'(r_exp.xv));
          chk("res_cause", result_xcpt_cause_o, r_exp.cause);
          chk("res_tval",  result_xcpt_tval_o, r_exp.tval);
        end
      end
      if (sb_valid_o === 1'b1) begin
        if (push_q.size() == 0) chk("unexpected_push", 1, 0);
        else begin
          p_exp = push_q.pop_front();
          chk("sb_paddr", 64'(sb_paddr_o), 64'(p_exp.paddr));
          chk("sb_data",  sb_data_o, p_exp.data);
          chk("sb_be",    64'(sb_be_o), 64'(p_exp.be));
          chk("sb_size",  64'(sb_data_size_o), 64'(p_exp.size));
          chk("sb_vwf",   64'(sb_valid_without_flush_o), 64'd1);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic smp();
    @(negedge clk_i);
  endtask

  task automatic drive_req(input logic [38:0] va, input logic [63:0] d,
                           input logic [1:0] sz, input logic [2:0] id);
    lsu_valid_i = 1'b1; vaddr_i = va; data_i = d; size_i = sz; trans_id_i = id;
  endtask

  task automatic idle_inputs();
    lsu_valid_i = 1'b0; dtlb_hit_i = 1'b0; xcpt_valid_i = 1'b0;
    sb_ready_i = 1'b0; flush_i = 1'b0; xcpt_cause_i = '0;
  endtask

  task automatic queues_empty(input string tag);
    chk({tag, "_resq"},  64'(res_q.size()), 64'd0);
    chk({tag, "_pushq"}, 64'(push_q.size()), 64'd0);
  endtask

  initial begin
    rst_ni = 1'b0; flush_i = 0; lsu_valid_i = 0; vaddr_i = '0; data_i = '0;
    size_i = '0; trans_id_i = '0; dtlb_hit_i = 0; paddr_i = '0;
    xcpt_valid_i = 0; xcpt_cause_i = '0; sb_ready_i = 0;
    smp(); smp();
    chk("rst_ready", 64'(lsu_ready_o), 64'd1);
    chk("rst_treq",  64'(translation_req_o), 64'd0);
    chk("rst_vaddr", 64'(vaddr_o), 64'd0);
    chk("rst_sb",    {sb_valid_o, sb_valid_without_flush_o, sb_be_o, sb_data_size_o}, 64'd0);
    chk("rst_sbdp",  sb_data_o | 64'(sb_paddr_o), 64'd0);
    chk("rst_res",   {result_valid_o, result_xcpt_valid_o, result_trans_id_o}, 64'd0);
    chk("rst_rescause", result_xcpt_cause_o | result_xcpt_tval_o, 64'd0);
    tick(); rst_ni = 1'b1;

    // 1: aligned dword, hit in N+1, store buffer ready.
    tick(); drive_req(39'h1000, 64'h1122334455667788, 2'd3, 3'd1);
    res_q.push_back('{3'd1, 1'b0, 64'd0, 64'd0});
    push_q.push_back('{56'h8000_1000, 64'h1122334455667788, 8'hFF, 2'd3});
    smp(); chk("t1_ready_n", 64'(lsu_ready_o), 64'd1);
    tick(); idle_inputs(); dtlb_hit_i = 1; paddr_i = 56'h8000_1000; sb_ready_i = 1;
    smp(); chk("t1_treq", 64'(translation_req_o), 64'd1);
    chk("t1_vaddr_o", 64'(vaddr_o), 64'h1000);
    chk("t1_ready_n1", 64'(lsu_ready_o), 64'd0);
    chk("t1_push", 64'(sb_valid_o), 64'd1);
    tick(); idle_inputs();
    smp(); chk("t1_ready_n2", 64'(lsu_ready_o), 64'd1);
    queues_empty("t1");

    // 2: halfword at 0x1006, three TLB miss cycles then hit.
    tick(); drive_req(39'h1006, 64'hABCD, 2'd1, 3'd2);
    res_q.push_back('{3'd2, 1'b0, 64'd0, 64'd0});
    push_q.push_back('{56'h9000_1006, 64'hABCD_0000_0000_0000, 8'hC0, 2'd1});
    smp();
    tick(); idle_inputs();
    for (int i = 0; i < 3; i++) begin
      smp(); chk("t2_miss_treq", 64'(translation_req_o), 64'd1);
      chk("t2_miss_nopush", 64'(sb_valid_o | result_valid_o), 64'd0);
      tick();
    end
    dtlb_hit_i = 1; paddr_i = 56'h9000_1006; sb_ready_i = 1;
    smp(); chk("t2_hit_treq", 64'(translation_req_o), 64'd1);
    chk("t2_push", 64'(sb_valid_o), 64'd1);
    tick(); idle_inputs();
    smp(); queues_empty("t2");

    // 3: word at 0x2004, store buffer busy two cycles; paddr must be latched.
    tick(); drive_req(39'h2004, 64'hDEADBEEF, 2'd2, 3'd3);
    res_q.push_back('{3'd3, 1'b0, 64'd0, 64'd0});
    push_q.push_back('{56'hA000_2004, 64'hDEADBEEF_0000_0000, 8'hF0, 2'd2});
    smp();
    tick(); idle_inputs(); dtlb_hit_i = 1; paddr_i = 56'hA000_2004;
    smp(); chk("t3_c1_nopush", 64'(sb_valid_o | result_valid_o), 64'd0);
    tick(); idle_inputs(); paddr_i = 56'h5555_5555;
    smp(); chk("t3_wait_treq", 64'(translation_req_o), 64'd0);
    chk("t3_wait_paddr", 64'(sb_paddr_o), 64'hA000_2004);
    chk("t3_wait_be", 64'(sb_be_o), 64'hF0);
    chk("t3_c2_nopush", 64'(sb_valid_o | result_valid_o), 64'd0);
    tick(); sb_ready_i = 1;
    smp(); chk("t3_push", 64'(sb_valid_o), 64'd1);
    tick(); idle_inputs();
    smp(); chk("t3_ready", 64'(lsu_ready_o), 64'd1);
    queues_empty("t3");

    // 4: misaligned halfword.
    tick(); drive_req(39'h1001, 64'h1234, 2'd1, 3'd4);
    res_q.push_back('{3'd4, 1'b1, 64'd6, 64'h1001});
    smp();
    tick(); idle_inputs(); dtlb_hit_i = 1; sb_ready_i = 1;
    smp(); chk("t4_treq", 64'(translation_req_o), 64'd0);
    chk("t4_nopush", 64'(sb_valid_o | sb_valid_without_flush_o), 64'd0);
    chk("t4_res", 64'(result_valid_o), 64'd1);
    tick(); idle_inputs();
    smp(); queues_empty("t4");

    // 5: translation fault.
    tick(); drive_req(39'h3000, 64'h77, 2'd3, 3'd5);
    res_q.push_back('{3'd5, 1'b1, 64'd15, 64'h3000});
    smp();
    tick(); idle_inputs(); dtlb_hit_i = 1; xcpt_valid_i = 1; xcpt_cause_i = 64'd15;
    sb_ready_i = 1; paddr_i = 56'hB000_3000;
    smp(); chk("t5_nopush", 64'(sb_valid_o | sb_valid_without_flush_o), 64'd0);
    chk("t5_res", 64'(result_valid_o), 64'd1);
    tick(); idle_inputs();
    smp(); queues_empty("t5");

    // 6: flush in the WAIT_SB cycle where the buffer becomes ready.
    tick(); drive_req(39'h4000, 64'h99, 2'd2, 3'd6);
    smp();
    tick(); idle_inputs(); dtlb_hit_i = 1; paddr_i = 56'hC000_4000;
    smp();
    tick(); idle_inputs(); sb_ready_i = 1; flush_i = 1;
    smp(); chk("t6_sbv", 64'(sb_valid_o), 64'd0);
    chk("t6_sbvwf", 64'(sb_valid_without_flush_o), 64'd1);
    chk("t6_nores", 64'(result_valid_o), 64'd0);
    tick(); idle_inputs();
    drive_req(39'h5008, 64'h0102030405060708, 2'd3, 3'd7);
    res_q.push_back('{3'd7, 1'b0, 64'd0, 64'd0});
    push_q.push_back('{56'hD000_5008, 64'h0102030405060708, 8'hFF, 2'd3});
    smp(); chk("t6_idle_ready", 64'(lsu_ready_o), 64'd1);
    tick(); idle_inputs(); dtlb_hit_i = 1; sb_ready_i = 1; paddr_i = 56'hD000_5008;
    smp(); chk("t6_accepted", 64'(lsu_ready_o), 64'd0);
    tick(); idle_inputs();
    smp(); queues_empty("t6");

    // 7: request offered in IDLE together with flush is not taken.
    tick(); drive_req(39'h6000, 64'h1, 2'd0, 3'd1); flush_i = 1;
    smp();
    tick(); idle_inputs();
    smp(); chk("t7_not_taken_ready", 64'(lsu_ready_o), 64'd1);
    chk("t7_not_taken_treq", 64'(translation_req_o), 64'd0);

    // 8: byte store at offset 5, then asynchronous reset mid-translation.
    tick(); drive_req(39'h7005, 64'h5A, 2'd0, 3'd2);
    smp();
    tick(); idle_inputs(); paddr_i = 56'hE000_7005;
    smp(); chk("t8_be", 64'(sb_be_o), 64'h20);
    chk("t8_data", sb_data_o, 64'h0000_5A00_0000_0000);
    tick(); dtlb_hit_i = 1; sb_ready_i = 1; rst_ni = 1'b0;
    #1;
    chk("t8_rst_nopush", 64'(sb_valid_o | result_valid_o), 64'd0);
    chk("t8_rst_ready", 64'(lsu_ready_o), 64'd1);
    chk("t8_rst_treq", 64'(translation_req_o), 64'd0);
    tick(); idle_inputs(); rst_ni = 1'b1;
    smp(); queues_empty("end");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
`default_nettype wire
